cnn_conv_layer_sequencer: RTL and testbench



---
 rtl/cnn_conv_pkg.sv | 32 +++
 rtl/cnn_stream_fwd.sv | 30 +++
 rtl/cnn_conv_layer_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_cnn_conv_layer_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_conv_pkg.sv
// rtl/cnn_conv_pkg.sv - Shared state enum and layer-size helpers for the conv layer family
package cnn_conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  function automatic int unsigned weight_num(input int unsigned cin, input int unsigned cout,
                                             input int unsigned k);
    return cin * cout * k * k;
  endfunction

  function automatic int unsigned pixel_num(input int unsigned cin, input int unsigned w,
                                            input int unsigned h);
    return cin * w * h;
  endfunction

  function automatic int unsigned out_num(input int unsigned cout, input int unsigned w,
                                          input int unsigned h);
    return cout * w * h;
  endfunction

  // Counter width able to index 0..n-1, never below one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_stream_fwd.sv
// rtl/cnn_stream_fwd.sv - One-cycle slice from a valid/ready source to a valid-only sink
module cnn_stream_fwd #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  s_tvalid_i,
  input  logic                  s_tready_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  output logic                  m_tvalid_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o
);

  logic                  tvalid_q;
  logic [DATA_WIDTH-1:0] tdata_q;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      tvalid_q <= s_tvalid_i & s_tready_i;
      if (s_tvalid_i & s_tready_i) tdata_q <= s_tdata_i;
    end
  end

  assign m_tvalid_o = tvalid_q;
  assign m_tdata_o  = tdata_q;

endmodule

// File: rtl/cnn_conv_layer_sequencer.sv
// rtl/cnn_conv_layer_sequencer.sv - Layer sequencer: weight load, pixel stream, output drain
module cnn_conv_layer_sequencer
  import cnn_conv_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int IMAGE_WIDTH     = 612,
  parameter int IMAGE_HEIGHT    = 612,
  parameter int CHANNEL_NUM_IN  = 64,
  parameter int CHANNEL_NUM_OUT = 64,
  parameter int KERNEL          = 3,
  parameter int DRAIN_TIMEOUT   = 4096
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 src_w_valid,
  input  logic [DATA_WIDTH-1:0]                src_w_data,
  output logic                                 src_w_ready,
  input  logic                                 src_px_valid,
  input  logic [DATA_WIDTH-1:0]                src_px_data,
  output logic                                 src_px_ready,
  output logic                                 conv_valid_weight_in,
  output logic [DATA_WIDTH-1:0]                conv_weight_in,
  output logic                                 conv_valid_in,
  output logic [DATA_WIDTH-1:0]                conv_pxl_in,
  input  logic                                 conv_valid_out,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic [cnt_width(CHANNEL_NUM_IN)-1:0] cur_ch
);

  localparam int unsigned WN     = weight_num(CHANNEL_NUM_IN, CHANNEL_NUM_OUT, KERNEL);
  localparam int unsigned ON     = out_num(CHANNEL_NUM_OUT, IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int unsigned WI_W   = cnt_width(WN);
  localparam int unsigned COL_W  = cnt_width(IMAGE_WIDTH);
  localparam int unsigned ROW_W  = cnt_width(IMAGE_HEIGHT);
  localparam int unsigned CH_W   = cnt_width(CHANNEL_NUM_IN);
  localparam int unsigned OUT_W  = cnt_width(ON + 1);
  localparam int unsigned IDLE_W = cnt_width(DRAIN_TIMEOUT + 1);

  localparam logic [WI_W-1:0]   W_LAST   = WI_W'(WN - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CHANNEL_NUM_IN - 1);
  localparam logic [OUT_W-1:0]  OUT_FULL = OUT_W'(ON);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(DRAIN_TIMEOUT);

  seq_state_e        state_q, state_d;
  logic [WI_W-1:0]   w_idx_q, w_idx_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              error_q, error_d;
  logic              w_fire, px_fire, clr;

  assign src_w_ready  = (state_q == ST_LOAD_W);
  assign src_px_ready = (state_q == ST_STREAM);
  assign busy         = (state_q == ST_LOAD_W) || (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign done         = (state_q == ST_DONE);
  assign error        = error_q;
  assign cur_ch       = ch_q;
  assign w_fire       = src_w_valid & src_w_ready;
  assign px_fire      = src_px_valid & src_px_ready;

  always_comb begin
    state_d   = state_q;
    w_idx_d   = w_idx_q;
    col_d     = col_q;
    row_d     = row_q;
    ch_d      = ch_q;
    out_cnt_d = out_cnt_q;
    idle_d    = idle_q;
    error_d   = error_q;
    clr       = 1'b0;

    // Strobes past OUT_NUM saturate rather than wrap
    if ((state_q == ST_STREAM || state_q == ST_DRAIN) && conv_valid_out && out_cnt_q != OUT_FULL)
      out_cnt_d = out_cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_LOAD_W;
        error_d = 1'b0;
        clr     = 1'b1;
      end
      ST_LOAD_W: if (w_fire) begin
        if (w_idx_q == W_LAST) state_d = ST_STREAM;
        else w_idx_d = w_idx_q + 1'b1;
      end
      ST_STREAM: if (px_fire) begin
        if (col_q != COL_LAST) col_d = col_q + 1'b1;
        else begin
          col_d = '0;
          if (row_q != ROW_LAST) row_d = row_q + 1'b1;
          else begin
            row_d = '0;
            if (ch_q != CH_LAST) ch_d = ch_q + 1'b1;
            else begin
              ch_d    = '0;
              idle_d  = '0;
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        // idle_q holds the number of cycles elapsed since the last strobe
        idle_d = conv_valid_out ? IDLE_W'(1) : idle_q + 1'b1;
        if (out_cnt_d == OUT_FULL) state_d = ST_DONE;
        else if (!conv_valid_out && (idle_q + 1'b1) == IDLE_MAX) begin
          state_d = ST_DONE;
          error_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        clr     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      clr     = 1'b1;
      if (busy) error_d = 1'b1;
    end

    if (clr) begin
      w_idx_d   = '0;
      col_d     = '0;
      row_d     = '0;
      ch_d      = '0;
      out_cnt_d = '0;
      idle_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      w_idx_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      ch_q      <= '0;
      out_cnt_q <= '0;
      idle_q    <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_idx_q   <= w_idx_d;
      col_q     <= col_d;
      row_q     <= row_d;
      ch_q      <= ch_d;
      out_cnt_q <= out_cnt_d;
      idle_q    <= idle_d;
      error_q   <= error_d;
    end
  end

  cnn_stream_fwd #(.DATA_WIDTH(DATA_WIDTH)) u_w_fwd (
    .clk_i     (clk),
    .resetn_i  (reset),
    .s_tvalid_i(src_w_valid),
    .s_tready_i(src_w_ready),
    .s_tdata_i (src_w_data),
    .m_tvalid_o(conv_valid_weight_in),
    .m_tdata_o (conv_weight_in)
  );

  cnn_stream_fwd #(.DATA_WIDTH(DATA_WIDTH)) u_px_fwd (
    .clk_i     (clk),
    .resetn_i  (reset),
    .s_tvalid_i(src_px_valid),
    .s_tready_i(src_px_ready),
    .s_tdata_i (src_px_data),
    .m_tvalid_o(conv_valid_in),
    .m_tdata_o (conv_pxl_in)
  );

endmodule

// File: tb/tb_cnn_conv_layer_sequencer.sv
// tb/tb_cnn_conv_layer_sequencer.sv - Directed bench: 4x4 image, CIN=COUT=2, DRAIN_TIMEOUT=16
module tb_cnn_conv_layer_sequencer;

  localparam int WEIGHTS = 36;
  localparam int PIXELS  = 32;
  localparam int OUTS    = 32;
  localparam int PER_CH  = 16;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic        src_w_valid, src_px_valid, conv_valid_out;
  logic [31:0] src_w_data, src_px_data;
  logic        src_w_ready, src_px_ready, conv_valid_weight_in, conv_valid_in;
  logic [31:0] conv_weight_in, conv_pxl_in;
  logic        busy, done, error;
  logic [0:0]  cur_ch;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic [31:0] w_next = 32'h1000_0000;
  logic [31:0] p_next = 32'h2000_0000;
  logic [31:0] exp_w[$], exp_p[$], got_w[$], got_p[$];

  cnn_conv_layer_sequencer #(
    .DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
    .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2), .KERNEL(3), .DRAIN_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .src_w_valid(src_w_valid), .src_w_data(src_w_data), .src_w_ready(src_w_ready),
    .src_px_valid(src_px_valid), .src_px_data(src_px_data), .src_px_ready(src_px_ready),
    .conv_valid_weight_in(conv_valid_weight_in), .conv_weight_in(conv_weight_in),
    .conv_valid_in(conv_valid_in), .conv_pxl_in(conv_pxl_in),
    .conv_valid_out(conv_valid_out), .busy(busy), .done(done), .error(error), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (conv_valid_weight_in) got_w.push_back(conv_weight_in);
    if (conv_valid_in) got_p.push_back(conv_pxl_in);
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, 64'({src_w_ready, src_px_ready, conv_valid_weight_in, conv_valid_in,
                            busy, done, error, cur_ch}), 64'd0);
    chk({tag, "_data"}, {conv_weight_in, conv_pxl_in}, 64'd0);
  endtask

  task automatic clear_logs();
    exp_w.delete(); exp_p.delete(); got_w.delete(); got_p.delete();
    done_cnt = 0;
  endtask

  task automatic send_weights(input int n, input bit bursty);
    int   k = 0;
    int   cyc = 0;
    logic acc;
    while (k < n && cyc < 400) begin
      src_w_valid = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
      src_w_data  = w_next;
      acc = src_w_valid && src_w_ready;
      tick();
      cyc++;
      if (acc) begin
        chk("fwd_w", 64'({conv_valid_weight_in, conv_weight_in}), 64'({1'b1, w_next}));
        exp_w.push_back(w_next);
        w_next++;
        k++;
      end else chk("gap_w", 64'(conv_valid_weight_in), 64'd0);
    end
    src_w_valid = 1'b0;
    if (k < n) chk("w_timeout", 64'(k), 64'(n));
  endtask

  task automatic send_pixels(input int n, input bit bursty);
    int   k = 0;
    int   cyc = 0;
    logic acc;
    while (k < n && cyc < 400) begin
      src_px_valid = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
      src_px_data  = p_next;
      acc = src_px_valid && src_px_ready;
      tick();
      cyc++;
      if (acc) begin
        chk("fwd_px", 64'({conv_valid_in, conv_pxl_in}), 64'({1'b1, p_next}));
        exp_p.push_back(p_next);
        p_next++;
        k++;
        if (k < PIXELS) chk("cur_ch", 64'(cur_ch), 64'((k / PER_CH) % 2));
      end else chk("gap_px", 64'(conv_valid_in), 64'd0);
    end
    src_px_valid = 1'b0;
    if (k < n) chk("px_timeout", 64'(k), 64'(n));
  endtask

  task automatic send_strobes(input int n);
    for (int i = 0; i < n; i++) begin
      conv_valid_out = 1'b1;
      tick();
      if (i < n - 1) chk("early_done", 64'(done), 64'd0);
    end
    conv_valid_out = 1'b0;
  endtask

  task automatic start_layer(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_start"}, 64'({busy, src_w_ready, src_px_ready, error}), 64'b1100);
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done"}, 64'({done, busy, error}), 64'b100);
    tick();
    chk({tag, "_idle"}, 64'({done, busy, src_w_ready, src_px_ready}), 64'b0000);
  endtask

  task automatic check_logs(input string tag);
    int bad_w = 0;
    int bad_p = 0;
    for (int i = 0; i < exp_w.size(); i++)
      if (i >= got_w.size() || got_w[i] !== exp_w[i]) bad_w++;
    for (int i = 0; i < exp_p.size(); i++)
      if (i >= got_p.size() || got_p[i] !== exp_p[i]) bad_p++;
    chk({tag, "_w_count"}, 64'(got_w.size()), 64'(WEIGHTS));
    chk({tag, "_w_order"}, 64'(bad_w), 64'd0);
    chk({tag, "_px_count"}, 64'(got_p.size()), 64'(PIXELS));
    chk({tag, "_px_order"}, 64'(bad_p), 64'd0);
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic full_pass(input string tag, input bit bursty);
    send_weights(WEIGHTS, bursty);
    chk({tag, "_handover"}, 64'({src_w_ready, src_px_ready}), 64'b01);
    send_pixels(PIXELS, bursty);
    chk({tag, "_drain"}, 64'({busy, src_px_ready, src_w_ready}), 64'b100);
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; abort = 1'b0; conv_valid_out = 1'b0;
    src_w_valid = 1'b0; src_px_valid = 1'b0; src_w_data = '0; src_px_data = '0;
    repeat (3) tick();
    chk_reset("reset");
    reset = 1'b1;
    tick();

    // Nominal pass
    clear_logs();
    start_layer("s1");
    full_pass("s1", 1'b0);
    send_strobes(OUTS);
    check_done("s1");
    check_logs("s1");

    // Bursty sources
    clear_logs();
    start_layer("s2");
    full_pass("s2", 1'b1);
    send_strobes(OUTS);
    check_done("s2");
    check_logs("s2");

    // Watchdog: 30 strobes, DONE expected 16 cycles after the last one
    clear_logs();
    start_layer("s3");
    full_pass("s3", 1'b0);
    send_strobes(30);
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("s3_wd_latency", 64'(n), 64'd16);
    chk("s3_wd_flags", 64'({done, busy, error}), 64'b101);
    tick();
    chk("s3_sticky", 64'({busy, src_w_ready, error}), 64'b001);

    // Abort mid-STREAM, with start in the same cycle
    clear_logs();
    start_layer("s4a");
    send_weights(WEIGHTS, 1'b0);
    send_pixels(10, 1'b0);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("s4_abort", 64'({busy, done, error, src_w_ready, src_px_ready}), 64'b00100);
    clear_logs();
    start_layer("s4b");
    full_pass("s4", 1'b0);
    send_strobes(OUTS);
    check_done("s4");
    check_logs("s4");

    // Reset mid-LOAD_W
    start_layer("s5a");
    send_weights(20, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_reset("s5_reset");
    clear_logs();
    start_layer("s5b");
    full_pass("s5", 1'b0);
    send_strobes(OUTS);
    check_done("s5");
    check_logs("s5");

    // Stray strobes in IDLE, ignored start in DRAIN
    conv_valid_out = 1'b1;
    repeat (3) tick();
    conv_valid_out = 1'b0;
    chk("s6_stray", 64'({busy, done, src_w_ready}), 64'b000);
    clear_logs();
    start_layer("s6");
    full_pass("s6", 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s6_start_ignored", 64'({busy, src_w_ready, src_px_ready, error}), 64'b1000);
    send_strobes(OUTS);
    check_done("s6");
    check_logs("s6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
